// File: rtl/mips_core_pkg.sv
// Shared predictor types: 2-bit PHT counter, its init value, saturating
// update helpers and the port-scheduler FSM state encoding.
package mips_core_pkg;

    typedef logic [1:0] pht_counter_t;

    localparam pht_counter_t PHT_INIT = 2'b01;  // weakly-not-taken

    typedef enum logic {PHT_INIT_S, PHT_RUN_S} pht_sched_state_t;

    function automatic pht_counter_t sat_inc(input pht_counter_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic pht_counter_t sat_dec(input pht_counter_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Counter value after a resolved branch with the given outcome.
    function automatic pht_counter_t pht_update(input pht_counter_t c, input logic taken);
        return taken ? sat_inc(c) : sat_dec(c);
    endfunction

endpackage

// File: rtl/pht_port_scheduler_if.sv
// Decode/execute-side bundle of the PHT port scheduler: prediction request,
// one-cycle response and execute feedback. master = pipeline, slave = scheduler.
interface pht_port_scheduler_if #(parameter int IDX_W = 10);
    import mips_core_pkg::*;

    logic             req_valid;
    logic [IDX_W-1:0] req_index;
    logic             req_ready;
    logic             rsp_valid;
    pht_counter_t     rsp_counter;
    logic             rsp_pred;
    logic             fb_valid;
    logic [IDX_W-1:0] fb_index;
    pht_counter_t     fb_counter;
    logic             fb_outcome;
    logic             fb_drop;

    modport master (
        output req_valid, req_index, fb_valid, fb_index, fb_counter, fb_outcome,
        input  req_ready, rsp_valid, rsp_counter, rsp_pred, fb_drop
    );

    modport slave (
        input  req_valid, req_index, fb_valid, fb_index, fb_counter, fb_outcome,
        output req_ready, rsp_valid, rsp_counter, rsp_pred, fb_drop
    );

endinterface

// File: rtl/pht_update_fifo.sv
// Circular queue of pending PHT writes {index, new counter}, with a
// youngest-match lookup so reads can see values not yet in the SRAM.
// The caller only pops when non-empty and only pushes into a full queue
// in the same cycle as a pop.
module pht_update_fifo
    import mips_core_pkg::*;
#(
    parameter int IDX_W  = 10,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_index,
    input  pht_counter_t     push_ctr,
    input  logic             pop,
    output logic [IDX_W-1:0] head_index,
    output pht_counter_t     head_ctr,
    output logic             full,
    output logic             empty,
    input  logic [IDX_W-1:0] lookup_index,
    output logic             lookup_hit,
    output pht_counter_t     lookup_ctr
);
    localparam int PTR_W = $clog2(QDEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        pht_counter_t     ctr;
    } entry_t;

    entry_t           entries_q [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign full       = (count_q == (PTR_W+1)'(QDEPTH));
    assign empty      = (count_q == '0);
    assign head_index = entries_q[rd_ptr_q].index;
    assign head_ctr   = entries_q[rd_ptr_q].ctr;

    // Pointer and occupancy bookkeeping.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // Walk live slots oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] slot;
        lookup_hit = 1'b0;
        lookup_ctr = PHT_INIT;
        slot       = rd_ptr_q;
        for (int i = 0; i < QDEPTH; i++) begin
            slot = rd_ptr_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (entries_q[slot].index == lookup_index)) begin
                lookup_hit = 1'b1;
                lookup_ctr = entries_q[slot].ctr;
            end
        end
    end

    // Queue control flops; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write.
    // NOTE: entry storage is not reset; count_q alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= '{index: push_index, ctr: push_ctr};
        end
    end

endmodule

// File: rtl/pht_port_scheduler.sv
// Shares one single-port PHT SRAM between decode prediction reads and
// execute counter updates. Updates are queued; reads bypass from the queue
// (or a same-cycle feedback) so they see the newest value. After reset an
// init sweep writes weakly-not-taken to every entry.
// Optional build macro PHT_SCHED_STATS_EN adds saturating event counters.
module pht_port_scheduler
    import mips_core_pkg::*;
#(
    parameter int IDX_W    = 10,
    parameter int QDEPTH   = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pht_port_scheduler_if.slave    bus,
    output logic                   init_done,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [IDX_W-1:0]       mem_addr,
    output pht_counter_t           mem_wdata,
    input  pht_counter_t           mem_rdata
`ifdef PHT_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_reads,
    output logic [31:0]            stat_writes,
    output logic [31:0]            stat_bypass,
    output logic [31:0]            stat_drops,
    output logic [31:0]            stat_forced
`endif
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    pht_sched_state_t  state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              init_done_q, init_done_d;
    logic              fb_drop_q, fb_drop_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              use_mem_q, use_mem_d;
    pht_counter_t      rsp_hold_q, rsp_hold_d;

    logic              req_ready_c, accept, force_wr, bypass;
    logic              do_push, do_pop, q_full, q_empty, lookup_hit;
    logic [IDX_W-1:0]  head_index;
    pht_counter_t      head_ctr, lookup_ctr, fb_new;

    assign fb_new = pht_update(bus.fb_counter, bus.fb_outcome);

    pht_update_fifo #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (do_push),
        .push_index   (bus.fb_index),
        .push_ctr     (fb_new),
        .pop          (do_pop),
        .head_index   (head_index),
        .head_ctr     (head_ctr),
        .full         (q_full),
        .empty        (q_empty),
        .lookup_index (bus.req_index),
        .lookup_hit   (lookup_hit),
        .lookup_ctr   (lookup_ctr)
    );

    // Next state, port arbitration, enqueue decision and wait counter.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wait_d      = wait_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = ptr_q;
        mem_wdata   = PHT_INIT;
        req_ready_c = 1'b0;
        accept      = 1'b0;
        force_wr    = 1'b0;
        do_pop      = 1'b0;
        do_push     = 1'b0;
        fb_drop_d   = 1'b0;
        unique case (state_q)
            PHT_INIT_S: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = PHT_INIT;
                ptr_d     = ptr_q + IDX_W'(1);
                if (ptr_q == '1) state_d = PHT_RUN_S;
                fb_drop_d = bus.fb_valid;
            end
            PHT_RUN_S: begin
                force_wr = !q_empty && (q_full || (wait_q == WAIT_W'(WAIT_MAX)));
                if (force_wr || (!bus.req_valid && !q_empty)) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = head_index;
                    mem_wdata = head_ctr;
                    do_pop    = 1'b1;
                end else if (bus.req_valid) begin
                    mem_en   = 1'b1;
                    mem_addr = bus.req_index;
                    accept   = 1'b1;
                end
                req_ready_c = !force_wr;
                do_push     = bus.fb_valid && (!q_full || do_pop);
                fb_drop_d   = bus.fb_valid && !do_push;
                if (do_pop)        wait_d = '0;
                else if (!q_empty) wait_d = wait_q + WAIT_W'(1);
            end
            default: state_d = PHT_INIT_S;
        endcase
        init_done_d = (state_d == PHT_RUN_S);
        // Keep the SRAM and the decode handshake quiet while reset is held.
        if (!rst_n) begin
            mem_en      = 1'b0;
            mem_we      = 1'b0;
            req_ready_c = 1'b0;
        end
    end

    // Bypass selection at acceptance: same-cycle feedback, then queue, then SRAM.
    always_comb begin
        rsp_valid_d = accept;
        use_mem_d   = 1'b0;
        rsp_hold_d  = rsp_hold_q;
        bypass      = 1'b0;
        if (accept) begin
            if (bus.fb_valid && (bus.fb_index == bus.req_index)) begin
                rsp_hold_d = fb_new;
                bypass     = 1'b1;
            end else if (lookup_hit) begin
                rsp_hold_d = lookup_ctr;
                bypass     = 1'b1;
            end else begin
                use_mem_d  = 1'b1;
            end
        end
    end

    // Scheduler state and response registers.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= PHT_INIT_S;
            ptr_q       <= '0;
            wait_q      <= '0;
            init_done_q <= 1'b0;
            fb_drop_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            use_mem_q   <= 1'b0;
            rsp_hold_q  <= PHT_INIT;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            init_done_q <= init_done_d;
            fb_drop_q   <= fb_drop_d;
            rsp_valid_q <= rsp_valid_d;
            use_mem_q   <= use_mem_d;
            rsp_hold_q  <= rsp_hold_d;
        end
    end

    assign init_done       = init_done_q;
    assign bus.req_ready   = req_ready_c;
    assign bus.fb_drop     = fb_drop_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_counter = use_mem_q ? mem_rdata : rsp_hold_q;
    assign bus.rsp_pred    = bus.rsp_counter[1];

`ifdef PHT_SCHED_STATS_EN
    logic [31:0] reads_q, reads_d, writes_q, writes_d, bypass_q, bypass_d;
    logic [31:0] drops_q, drops_d, forced_q, forced_d;
    logic        in_run;

    assign in_run = (state_q == PHT_RUN_S);

    // Saturating event counters, RUN-state events only.
    always_comb begin
        reads_d  = reads_q  + 32'((accept             && reads_q  != '1) ? 1 : 0);
        writes_d = writes_q + 32'((do_pop             && writes_q != '1) ? 1 : 0);
        bypass_d = bypass_q + 32'((bypass             && bypass_q != '1) ? 1 : 0);
        drops_d  = drops_q  + 32'((in_run && fb_drop_d && drops_q != '1) ? 1 : 0);
        forced_d = forced_q + 32'((force_wr           && forced_q != '1) ? 1 : 0);
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reads_q  <= '0;
            writes_q <= '0;
            bypass_q <= '0;
            drops_q  <= '0;
            forced_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            bypass_q <= bypass_d;
            drops_q  <= drops_d;
            forced_q <= forced_d;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_bypass = bypass_q;
    assign stat_drops  = drops_q;
    assign stat_forced = forced_q;
`endif

endmodule

// File: tb/tb_pht_port_scheduler.sv
// Self-checking bench for pht_port_scheduler (IDX_W=4, QDEPTH=4, WAIT_MAX=8).
// A behavioural model (logical table + pending-update queue) predicts every
// cycle's port activity and responses; directed sequences cover the corners.
module tb_pht_port_scheduler;
    import mips_core_pkg::*;

    localparam int IDX_W    = 4;
    localparam int QDEPTH   = 4;
    localparam int WAIT_MAX = 8;
    localparam int N        = 1 << IDX_W;

    logic             clk;
    logic             rst_n;
    logic             init_done, mem_en, mem_we;
    logic [IDX_W-1:0] mem_addr;
    pht_counter_t     mem_wdata, mem_rdata;
`ifdef PHT_SCHED_STATS_EN
    logic [31:0]      stat_reads, stat_writes, stat_bypass, stat_drops, stat_forced;
`endif

    pht_port_scheduler_if #(.IDX_W(IDX_W)) bus ();

    pht_port_scheduler #(.IDX_W(IDX_W), .QDEPTH(QDEPTH), .WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .init_done (init_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef PHT_SCHED_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_bypass (stat_bypass),
        .stat_drops  (stat_drops),
        .stat_forced (stat_forced)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM with one-cycle read latency.
    pht_counter_t sram [N];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       val;
    } qent_t;

    qent_t      mq[$];
    logic [1:0] mtab [N];
    bit         m_run;
    int         m_ptr, m_wait;
    bit         e_rsp_valid, e_drop, e_done;
    logic [1:0] e_rsp;

    logic             o_ready, o_en, o_we, o_rsp_valid, o_pred, o_drop;
    logic [IDX_W-1:0] o_addr;
    logic [1:0]       o_wdata, o_rsp;

    int n_vec, n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_update(input logic [1:0] c, input logic taken);
        int v;
        v = int'(c) + (taken ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    // Newest logical value of an index as seen by a read this cycle.
    function automatic logic [1:0] newest(input logic [IDX_W-1:0] idx);
        if (bus.fb_valid && bus.fb_index == idx) return ref_update(bus.fb_counter, bus.fb_outcome);
        for (int k = mq.size() - 1; k >= 0; k--)
            if (mq[k].idx == idx) return mq[k].val;
        return mtab[idx];
    endfunction

    task automatic model_reset();
        m_run = 0; m_ptr = 0; m_wait = 0; mq.delete();
        e_rsp_valid = 0; e_drop = 0; e_done = 0; e_rsp = 2'b01;
    endtask

    // Called mid-cycle with inputs stable: compare, then advance model to the next edge.
    task automatic model_step();
        bit full, nonempty, force_w, wr, rd;
        o_ready = bus.req_ready; o_en = mem_en; o_we = mem_we; o_addr = mem_addr;
        o_wdata = mem_wdata; o_rsp_valid = bus.rsp_valid; o_rsp = bus.rsp_counter;
        o_pred = bus.rsp_pred; o_drop = bus.fb_drop;
        check("rsp_valid", o_rsp_valid, e_rsp_valid);
        if (e_rsp_valid) begin
            check("rsp_counter", o_rsp, e_rsp);
            check("rsp_pred", o_pred, e_rsp[1]);
        end
        check("fb_drop", o_drop, e_drop);
        check("init_done", init_done, e_done);
        if (!rst_n) begin
            check("ready_in_reset", o_ready, 0);
            check("mem_en_in_reset", o_en, 0);
            model_reset();
            return;
        end
        e_rsp_valid = 0;
        e_drop      = 0;
        if (!m_run) begin
            check("init_ready", o_ready, 0);
            check("init_en", o_en, 1);
            check("init_we", o_we, 1);
            check("init_addr", o_addr, m_ptr);
            check("init_wdata", o_wdata, 2'b01);
            mtab[m_ptr] = 2'b01;
            e_drop = bus.fb_valid;
            m_ptr++;
            if (m_ptr == N) m_run = 1;
            e_done = m_run;
            return;
        end
        nonempty = mq.size() > 0;
        full     = mq.size() == QDEPTH;
        force_w  = nonempty && (full || m_wait >= WAIT_MAX);
        wr       = force_w || (nonempty && !bus.req_valid);
        rd       = !force_w && bus.req_valid;
        check("req_ready", o_ready, !force_w);
        check("mem_en", o_en, wr || rd);
        if (wr) begin
            check("wr_we", o_we, 1);
            check("wr_addr", o_addr, mq[0].idx);
            check("wr_wdata", o_wdata, mq[0].val);
            mtab[mq[0].idx] = mq[0].val;
            void'(mq.pop_front());
        end else if (rd) begin
            check("rd_we", o_we, 0);
            check("rd_addr", o_addr, bus.req_index);
            e_rsp       = newest(bus.req_index);
            e_rsp_valid = 1;
        end
        if (bus.fb_valid) begin
            if (mq.size() < QDEPTH)
                mq.push_back('{idx: bus.fb_index, val: ref_update(bus.fb_counter, bus.fb_outcome)});
            else
                e_drop = 1;
        end
        if (wr)            m_wait = 0;
        else if (nonempty) m_wait++;
        e_done = 1;
    endtask

    // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic cycle(input bit rv, input int ri, input bit fv, input int fi,
                         input int fc, input bit fo, input bit rn);
        bus.req_valid  = rv;
        bus.req_index  = IDX_W'(ri);
        bus.fb_valid   = fv;
        bus.fb_index   = IDX_W'(fi);
        bus.fb_counter = 2'(fc);
        bus.fb_outcome = fo;
        rst_n          = rn;
        #4;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    typedef struct packed {
        logic [1:0] ctr;
        logic       outcome;
        logic [1:0] exp;
    } upd_vec_t;

    upd_vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit seen;
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{2'b00, 1'b0, 2'b00};
        vecs[1] = '{2'b00, 1'b1, 2'b01};
        vecs[2] = '{2'b01, 1'b0, 2'b00};
        vecs[3] = '{2'b01, 1'b1, 2'b10};
        vecs[4] = '{2'b10, 1'b0, 2'b01};
        vecs[5] = '{2'b10, 1'b1, 2'b11};
        vecs[6] = '{2'b11, 1'b0, 2'b10};
        vecs[7] = '{2'b11, 1'b1, 2'b11};

        bus.req_valid = 0; bus.req_index = '0; bus.fb_valid = 0;
        bus.fb_index = '0; bus.fb_counter = '0; bus.fb_outcome = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_counter", bus.rsp_counter, 2'b01);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_mem_en", mem_en, 0);
        check("reset_fb_drop", bus.fb_drop, 0);
        check("reset_init_done", init_done, 0);

        // Init sweep; a feedback during the sweep is dropped.
        for (int i = 0; i < N; i++) begin
            cycle(0, 0, (i == 2), 6, 1, 1, 1);
            check("sweep_addr", o_addr, i);
            check("sweep_we", o_we, 1);
            if (i == 3) check("init_fb_drop", o_drop, 1);
        end
        check("sweep_done", init_done, 1);
        check("sweep_ready", bus.req_ready, 1);

        // Single update then read-back from SRAM.
        cycle(0, 0, 1, 3, 1, 1, 1);
        idle(1);
        check("upd_we", o_we, 1);
        check("upd_addr", o_addr, 3);
        check("upd_wdata", o_wdata, 2'b10);
        cycle(1, 3, 0, 0, 0, 0, 1);
        idle(1);
        check("rd3_valid", o_rsp_valid, 1);
        check("rd3_counter", o_rsp, 2'b10);
        check("rd3_pred", o_pred, 1);

        // Fill the queue under continuous requests, then forced write.
        for (int k = 0; k < QDEPTH; k++) cycle(1, $urandom_range(0, N-1), 1, 8 + k, 2, 0, 1);
        cycle(1, 0, 1, 12, 0, 0, 1);
        check("full_ready", o_ready, 0);
        check("full_forced_we", o_we, 1);
        check("full_forced_addr", o_addr, 8);
        idle(1);
        check("full_fb_accepted", o_drop, 0);
        idle(6);

        // Queue bypass and same-cycle feedback bypass.
        cycle(1, 0, 1, 5, 2, 1, 1);
        cycle(1, 5, 0, 0, 0, 0, 1);
        idle(1);
        check("byp_q_valid", o_rsp_valid, 1);
        check("byp_q_counter", o_rsp, 2'b11);
        cycle(1, 7, 1, 7, 0, 0, 1);
        idle(1);
        check("byp_fb_counter", o_rsp, 2'b00);
        idle(3);

        // Starvation bound.
        cycle(0, 0, 1, 9, 1, 1, 1);
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle(1, 2, 0, 0, 0, 0, 1);
            if (!o_ready) seen = 1;
            else cnt++;
        end
        check("wait_forced_seen", seen, 1);
        check("wait_denied_cycles", cnt, WAIT_MAX);
        check("wait_forced_addr", o_addr, 9);
        idle(2);

        // Reset mid-RUN with 3 queued entries and a response in flight.
        for (int k = 0; k < 3; k++) cycle(1, 1, 1, 10 + k, 3, 1, 1);
        cycle(1, 4, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_init_done", init_done, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            check("resweep_addr", o_addr, i);
        end
        idle(1);
        check("rst_queue_empty", o_en, 0);

        // Update-rule table, including both saturation points.
        for (int v = 0; v < 8; v++) begin
            cycle(0, 0, 1, v + 1, vecs[v].ctr, vecs[v].outcome, 1);
            idle(1);
            check("vec_addr", o_addr, v + 1);
            check("vec_wdata", o_wdata, vecs[v].exp);
        end

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, N-1),
                  $urandom_range(0, 99) < 50, $urandom_range(0, N-1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 399) != 0);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
